// File: rtl/axis_pkg.sv
// Shared AXI-stream payload types and the sample framer state encoding.
package axis_pkg;

  typedef struct packed {
    logic [15:0] re;
    logic [15:0] im;
  } sample_t_int;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RUN       = 2'd1,
    STOP_PEND = 2'd2
  } framer_state_e;

endpackage

// File: rtl/sample_framer.sv
// Packs a serial sample stream into BUS_NUM-wide beats, FFT_SIZE samples per
// frame, with start/stop control and a completed-frame counter.
module sample_framer
  import axis_pkg::*;
#(
  parameter int unsigned FFT_SIZE = 8192,
  parameter int unsigned BUS_NUM  = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_tvalid,
  output logic        in_tready,
  input  sample_t_int in_tdata,
  output logic        out_tvalid,
  input  logic        out_tready,
  output logic        out_tlast,
  output sample_t_int out_tdata [BUS_NUM],
  input  logic        ctrl_start,
  input  logic        ctrl_stop,
  output logic        busy,
  output logic [31:0] frame_cnt
);

  localparam int unsigned BEATS  = FFT_SIZE / BUS_NUM;
  localparam int unsigned LANE_W = $clog2(BUS_NUM);
  localparam int unsigned BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [LANE_W-1:0] LANE_LAST = LANE_W'(BUS_NUM - 1);
  localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BEATS - 1);

  framer_state_e     state_q, state_d;
  logic [LANE_W-1:0] lane_q;
  logic [BEAT_W-1:0] beat_q;
  sample_t_int       asm_q [BUS_NUM-1];

  logic take, lane_last, frame_end, load, out_hs, at_boundary;

  assign lane_last   = (lane_q == LANE_LAST);
  assign frame_end   = lane_last && (beat_q == BEAT_LAST);
  assign at_boundary = (lane_q == '0) && (beat_q == '0);
  assign take        = in_tvalid && in_tready && (state_q != IDLE);
  assign load        = take && lane_last;
  assign out_hs      = out_tvalid && out_tready;

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // A stop that coincides with the last sample of a frame ends immediately
  // rather than waiting out a whole extra frame in STOP_PEND.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (ctrl_start && !ctrl_stop) state_d = RUN;
      end
      RUN: begin
        if (ctrl_stop) begin
          if (at_boundary || (take && frame_end)) state_d = IDLE;
          else                                    state_d = STOP_PEND;
        end
      end
      STOP_PEND: begin
        if (take && frame_end) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Only the lane that completes a beat can be back-pressured by the output.
  always_comb begin
    in_tready = 1'b0;
    busy      = out_tvalid;
    if (!rst) begin
      if (state_q == IDLE) in_tready = 1'b1;
      else                 in_tready = !lane_last || !out_tvalid || out_tready;
    end
    if (state_q != IDLE) busy = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst || (state_d == IDLE)) begin
      lane_q <= '0;
      beat_q <= '0;
    end else if (take) begin
      lane_q <= lane_last ? '0 : lane_q + LANE_W'(1);
      if (lane_last) beat_q <= (beat_q == BEAT_LAST) ? '0 : beat_q + BEAT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < BUS_NUM - 1; i++) asm_q[i] <= '0;
    end else if (take && !lane_last) begin
      for (int unsigned i = 0; i < BUS_NUM - 1; i++) begin
        if (lane_q == LANE_W'(i)) asm_q[i] <= in_tdata;
      end
    end
  end

  // The output register only loads when it is empty or draining this cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_tvalid <= 1'b0;
      out_tlast  <= 1'b0;
      for (int unsigned i = 0; i < BUS_NUM; i++) out_tdata[i] <= '0;
    end else if (load) begin
      out_tvalid <= 1'b1;
      out_tlast  <= (beat_q == BEAT_LAST);
      for (int unsigned i = 0; i < BUS_NUM - 1; i++) out_tdata[i] <= asm_q[i];
      out_tdata[BUS_NUM-1] <= in_tdata;
    end else if (out_hs) begin
      out_tvalid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)                      frame_cnt <= '0;
    else if (out_hs && out_tlast) frame_cnt <= frame_cnt + 32'd1;
  end

endmodule

// File: tb/tb_sample_framer.sv
// Randomized self-checking bench for sample_framer (FFT_SIZE=16, BUS_NUM=2).
module tb_sample_framer;
  import axis_pkg::*;

  localparam int unsigned FFT_SIZE = 16;
  localparam int unsigned BUS_NUM  = 2;
  localparam int unsigned BEATS    = FFT_SIZE / BUS_NUM;

  typedef struct packed {
    sample_t_int s0;
    sample_t_int s1;
    logic        last;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_tvalid, in_tready, out_tvalid, out_tready, out_tlast;
  logic        ctrl_start, ctrl_stop, busy;
  logic [31:0] frame_cnt;
  sample_t_int in_tdata;
  sample_t_int out_tdata [BUS_NUM];

  sample_framer #(.FFT_SIZE(FFT_SIZE), .BUS_NUM(BUS_NUM)) dut (
    .clk(clk), .rst(rst),
    .in_tvalid(in_tvalid), .in_tready(in_tready), .in_tdata(in_tdata),
    .out_tvalid(out_tvalid), .out_tready(out_tready), .out_tlast(out_tlast),
    .out_tdata(out_tdata),
    .ctrl_start(ctrl_start), .ctrl_stop(ctrl_stop),
    .busy(busy), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  int pass_cnt = 0;
  int total_cnt = 0;
  int exp_frames = 0;
  bit rand_ready = 1'b0;
  bit track_tready = 1'b0;

  sample_t_int tx_q[$];
  sample_t_int acc_q[$];
  beat_t       exp_q[$];
  beat_t       got_q[$];

  beat_t cur, prev_beat;
  bit    prev_stalled;
  int    stall_viol = 0;
  int    tready_drops = 0;

  assign cur = {out_tdata[0], out_tdata[1], out_tlast};

  // Output monitor: collects handshaken beats and watches stall stability.
  always @(negedge clk) begin
    if (rst) begin
      prev_stalled <= 1'b0;
    end else begin
      if (prev_stalled && (out_tvalid !== 1'b1 || cur !== prev_beat)) stall_viol <= stall_viol + 1;
      prev_stalled <= out_tvalid && !out_tready;
      prev_beat    <= cur;
      if (out_tvalid && out_tready) got_q.push_back(cur);
      if (track_tready && in_tready !== 1'b1) tready_drops <= tready_drops + 1;
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic sample_t_int mk(input int n);
    sample_t_int s;
    s.re = 16'(n);
    s.im = 16'(-n);
    return s;
  endfunction

  // Reference: consecutive framed samples pair up into beats; every
  // FFT_SIZE/BUS_NUM-th beat closes a frame.
  task automatic model_frames();
    beat_t b;
    exp_q.delete();
    for (int k = 0; k < acc_q.size() / 2; k++) begin
      b.s0   = acc_q[2*k];
      b.s1   = acc_q[2*k+1];
      b.last = ((k % BEATS) == BEATS - 1);
      exp_q.push_back(b);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
    if (rand_ready) out_tready = 1'($urandom_range(0, 1));
  endtask

  task automatic pulse(input logic s, input logic p);
    ctrl_start = s;
    ctrl_stop  = p;
    cycle();
    ctrl_start = 1'b0;
    ctrl_stop  = 1'b0;
  endtask

  task automatic send_q(input bit gaps);
    bit hs;
    int guard;
    while (tx_q.size() > 0) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        in_tvalid = 1'b0;
        cycle();
      end else begin
        in_tvalid = 1'b1;
        in_tdata  = tx_q[0];
        guard = 0;
        hs = 1'b0;
        while (!hs && guard < 200) begin
          @(negedge clk);
          hs = in_tready;
          cycle();
          guard++;
        end
        if (!hs) begin
          total_cnt++;
          $display("FAIL send_timeout: in_tready stuck at 0, %0d samples left", tx_q.size());
          tx_q.delete();
        end else begin
          tx_q.delete(0);
        end
      end
    end
    in_tvalid = 1'b0;
  endtask

  task automatic drain();
    int idle = 0;
    for (int i = 0; i < 2000 && idle < 4; i++) begin
      @(negedge clk);
      idle = out_tvalid ? 0 : idle + 1;
      cycle();
    end
    if (idle < 4) begin
      total_cnt++;
      $display("FAIL drain_timeout: out_tvalid never settled low");
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_tvalid = 1'b0; in_tdata = '0;
    ctrl_start = 1'b0; ctrl_stop = 1'b0; out_tready = 1'b1;
    repeat (2) cycle();
    @(negedge clk);
    total_cnt++;
    if (in_tready !== 1'b0) $display("FAIL reset_tready: got %b want 0", in_tready);
    else pass_cnt++;
    total_cnt++;
    if ({out_tvalid, out_tlast, busy} !== 3'b000)
      $display("FAIL reset_flags: got valid/last/busy %b%b%b want 000", out_tvalid, out_tlast, busy);
    else pass_cnt++;
    total_cnt++;
    if (frame_cnt !== 32'd0) $display("FAIL reset_frame_cnt: got %0d want 0", frame_cnt);
    else pass_cnt++;
    total_cnt++;
    if (out_tdata[0] !== '0 || out_tdata[1] !== '0)
      $display("FAIL reset_tdata: got %h %h want 0", out_tdata[0], out_tdata[1]);
    else pass_cnt++;
    cycle();
    rst = 1'b0;
    cycle();
    @(negedge clk);
    total_cnt++;
    if (in_tready !== 1'b1 || busy !== 1'b0)
      $display("FAIL idle_ready: got tready %b busy %b want 1 0", in_tready, busy);
    else pass_cnt++;
    exp_frames = 0;
  endtask

  task automatic test_stream();
    int drops0 = tready_drops;
    acc_q.delete(); got_q.delete();
    track_tready = 1'b1;
    pulse(1'b1, 1'b0);
    for (int n = 0; n < 32; n++) tx_q.push_back(mk(n));
    acc_q = tx_q;
    send_q(1'b0);
    drain();
    track_tready = 1'b0;
    model_frames();
    exp_frames += acc_q.size() / FFT_SIZE;
    total_cnt++;
    if (got_q.size() != exp_q.size()) $display("FAIL stream_count: got %0d want %0d", got_q.size(), exp_q.size());
    else pass_cnt++;
    for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
      total_cnt++;
      if (got_q[k] !== exp_q[k]) $display("FAIL stream_beat %0d: got %h want %h", k, got_q[k], exp_q[k]);
      else pass_cnt++;
    end
    total_cnt++;
    if (frame_cnt !== 32'(exp_frames)) $display("FAIL stream_frame_cnt: got %0d want %0d", frame_cnt, exp_frames);
    else pass_cnt++;
    total_cnt++;
    if (tready_drops != drops0) $display("FAIL stream_tready: got %0d drops want 0", tready_drops - drops0);
    else pass_cnt++;
    pulse(1'b0, 1'b1);
    @(negedge clk);
    total_cnt++;
    if (busy !== 1'b0) $display("FAIL stream_stop_idle: got busy %b want 0", busy);
    else pass_cnt++;
  endtask

  task automatic test_stall();
    int viol0 = stall_viol;
    acc_q.delete(); got_q.delete();
    pulse(1'b1, 1'b0);
    rand_ready = 1'b1;
    for (int n = 0; n < 64; n++) tx_q.push_back(mk(n));
    acc_q = tx_q;
    send_q(1'b1);
    pulse(1'b0, 1'b1);
    drain();
    rand_ready = 1'b0;
    out_tready = 1'b1;
    model_frames();
    exp_frames += acc_q.size() / FFT_SIZE;
    total_cnt++;
    if (got_q.size() != exp_q.size()) $display("FAIL stall_count: got %0d want %0d", got_q.size(), exp_q.size());
    else pass_cnt++;
    for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
      total_cnt++;
      if (got_q[k] !== exp_q[k]) $display("FAIL stall_beat %0d: got %h want %h", k, got_q[k], exp_q[k]);
      else pass_cnt++;
    end
    total_cnt++;
    if (stall_viol != viol0) $display("FAIL stall_stable: got %0d changes while stalled want 0", stall_viol - viol0);
    else pass_cnt++;
    total_cnt++;
    if (frame_cnt !== 32'(exp_frames)) $display("FAIL stall_frame_cnt: got %0d want %0d", frame_cnt, exp_frames);
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if (busy !== 1'b0) $display("FAIL stall_idle: got busy %b want 0", busy);
    else pass_cnt++;
  endtask

  task automatic test_stop_mid();
    acc_q.delete(); got_q.delete();
    pulse(1'b1, 1'b0);
    for (int n = 0; n < 16; n++) acc_q.push_back(mk(n + 200));
    for (int n = 0; n < 6; n++) tx_q.push_back(mk(n + 200));
    send_q(1'b0);
    pulse(1'b0, 1'b1);
    for (int n = 6; n < 16; n++) tx_q.push_back(mk(n + 200));
    send_q(1'b1);
    for (int i = 0; i < 4; i++) begin
      in_tvalid = 1'b1;
      in_tdata  = mk(900 + i);
      @(negedge clk);
      total_cnt++;
      if (in_tready !== 1'b1) $display("FAIL stop_discard_ready %0d: got %b want 1", i, in_tready);
      else pass_cnt++;
      cycle();
    end
    in_tvalid = 1'b0;
    drain();
    model_frames();
    exp_frames += acc_q.size() / FFT_SIZE;
    total_cnt++;
    if (got_q.size() != exp_q.size()) $display("FAIL stop_count: got %0d want %0d", got_q.size(), exp_q.size());
    else pass_cnt++;
    for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
      total_cnt++;
      if (got_q[k] !== exp_q[k]) $display("FAIL stop_beat %0d: got %h want %h", k, got_q[k], exp_q[k]);
      else pass_cnt++;
    end
    total_cnt++;
    if (frame_cnt !== 32'(exp_frames)) $display("FAIL stop_frame_cnt: got %0d want %0d", frame_cnt, exp_frames);
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if (busy !== 1'b0) $display("FAIL stop_idle: got busy %b want 0", busy);
    else pass_cnt++;
  endtask

  task automatic test_start_stop_same();
    got_q.delete();
    pulse(1'b1, 1'b1);
    for (int n = 0; n < 4; n++) tx_q.push_back(mk(n + 50));
    send_q(1'b0);
    drain();
    total_cnt++;
    if (got_q.size() != 0 || busy !== 1'b0)
      $display("FAIL start_stop_same: got %0d beats busy %b want 0 beats busy 0", got_q.size(), busy);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    pulse(1'b1, 1'b0);
    for (int n = 0; n < 10; n++) tx_q.push_back(mk(n + 300));
    send_q(1'b0);
    rst = 1'b1;
    repeat (2) cycle();
    rst = 1'b0;
    got_q.delete(); acc_q.delete();
    exp_frames = 0;
    @(negedge clk);
    total_cnt++;
    if (frame_cnt !== 32'd0 || out_tvalid !== 1'b0)
      $display("FAIL rstmid_clear: got frame_cnt %0d valid %b want 0 0", frame_cnt, out_tvalid);
    else pass_cnt++;
    cycle();
    pulse(1'b1, 1'b0);
    rand_ready = 1'b1;
    for (int n = 0; n < 16; n++) tx_q.push_back(sample_t_int'(32'($urandom)));
    acc_q = tx_q;
    send_q(1'b1);
    drain();
    rand_ready = 1'b0;
    out_tready = 1'b1;
    model_frames();
    exp_frames += acc_q.size() / FFT_SIZE;
    total_cnt++;
    if (got_q.size() != exp_q.size()) $display("FAIL rstmid_count: got %0d want %0d", got_q.size(), exp_q.size());
    else pass_cnt++;
    for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
      total_cnt++;
      if (got_q[k] !== exp_q[k]) $display("FAIL rstmid_beat %0d: got %h want %h", k, got_q[k], exp_q[k]);
      else pass_cnt++;
    end
    total_cnt++;
    if (frame_cnt !== 32'(exp_frames)) $display("FAIL rstmid_frame_cnt: got %0d want %0d", frame_cnt, exp_frames);
    else pass_cnt++;
    pulse(1'b0, 1'b1);
    @(negedge clk);
    total_cnt++;
    if (busy !== 1'b0) $display("FAIL rstmid_idle: got busy %b want 0", busy);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_stop_mid();
    test_start_stop_same();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/sample_framer.md
SAMPLE_FRAMER -- requirements
Module: sample_framer

Interface
REQ-001 Parameter FFT_SIZE, default 8192: samples per frame; power of 2.
REQ-002 Parameter BUS_NUM, default 2: output lanes per beat; power of 2, >= 2, divides FFT_SIZE.
REQ-003 Port clk  input  1  the single clock of the block; all logic on its rising edge.
REQ-004 Port rst  input  1  reset; synchronous and active-high.
REQ-005 Port in_tvalid  input  1  AXIS input valid; one sample per beat; no tlast.
REQ-006 Port in_tready  output  1  AXIS input ready.
REQ-007 Port in_tdata  input  sample_t_int  input sample (16-bit re, 16-bit im).
REQ-008 Port out_tvalid  output  1  AXIS output valid.
REQ-009 Port out_tready  input  1  AXIS output ready.
REQ-010 Port out_tlast  output  1  last beat of a frame.
REQ-011 Port out_tdata  output  sample_t_int [BUS_NUM]  packed samples; lane 0 = earliest sample.
REQ-012 Port ctrl_start  input  1  single-cycle pulse; begin framing.
REQ-013 Port ctrl_stop  input  1  single-cycle pulse; stop after the current frame.
REQ-014 Port busy  output  1  high when state != IDLE or out_tvalid = 1.
REQ-015 Port frame_cnt  output  32  count of completed output frames.

Function
REQ-016 FSM states: IDLE, RUN, STOP_PEND.
REQ-017 IDLE: in_tready = 1; accepted samples are discarded; lane and beat counters are held at 0.
REQ-018 IDLE with ctrl_start = 1 and ctrl_stop = 0 -> RUN on the next cycle.
REQ-019 ctrl_start in RUN or STOP_PEND is ignored.
REQ-020 If ctrl_start and ctrl_stop are both high in the same cycle, ctrl_stop wins.
REQ-021 RUN with ctrl_stop at a frame boundary (lane = 0, beat = 0) -> IDLE.
REQ-022 RUN with ctrl_stop mid-frame -> STOP_PEND.
REQ-023 STOP_PEND -> IDLE on the input handshake of the frame's last sample.
REQ-024 Lane counter: 0..BUS_NUM-1; increments on each input handshake in RUN/STOP_PEND; wraps to 0.
REQ-025 Lanes 0..BUS_NUM-2 are written into an assembly register.
REQ-026 The sample at lane BUS_NUM-1 is loaded, together with the assembly register, into the output register in the same cycle, setting out_tvalid.
REQ-027 In RUN/STOP_PEND: in_tready = (lane != BUS_NUM-1) | !out_tvalid | out_tready. This gives full throughput with no bubble.
REQ-028 Latency: the output beat is valid the cycle after the handshake of its last lane sample.
REQ-029 Beat counter: 0..FFT_SIZE/BUS_NUM-1; increments per assembled beat; wraps to 0.
REQ-030 out_tlast = 1 for the beat that completes count FFT_SIZE/BUS_NUM-1.
REQ-031 out_tvalid, out_tdata and out_tlast are held stable while out_tvalid = 1 and out_tready = 0.
REQ-032 A pending output beat is never dropped, including after a transition to IDLE.
REQ-033 out_tvalid clears on handshake unless a new beat loads in the same cycle.
REQ-034 frame_cnt increments on each output handshake with out_tlast = 1; it wraps modulo 2^32.
REQ-035 There is no combinational path from out_tready to out_tvalid.

Reset
REQ-036 On rst = 1 at a clock edge, the following values apply:
- state = IDLE
- lane and beat counters = 0
- out_tvalid = 0, out_tlast = 0, out_tdata = all zeros
- frame_cnt = 0
- busy = 0
REQ-037 Reset mid-frame discards the partial frame, and the next frame after ctrl_start starts at lane 0, beat 0.
REQ-038 During reset in_tready = 0.

Structure
REQ-039 sample_t_int is taken from axis_pkg.
REQ-040 The FSM state enum type is added to axis_pkg.
REQ-041 No sub-modules.

Verification
REQ-042 All scenarios use FFT_SIZE = 16, BUS_NUM = 2.
REQ-043 Start, stream 0..31 (re = n, im = -n), out_tready = 1 -> 16 beats {0,1},{2,3}...; tlast on beats 8 and 16; frame_cnt = 2; no in_tready deassertion.
REQ-044 out_tready toggled randomly (50%) over 64 samples -> output data sequence identical to REQ-043; beat data stable while stalled; no loss or duplication.
REQ-045 ctrl_stop after sample 5 -> samples 6..15 still framed; tlast on beat 8; state IDLE afterwards; later samples discarded with in_tready = 1.
REQ-046 ctrl_start and ctrl_stop in the same cycle while IDLE -> remains IDLE; no output.
REQ-047 rst after sample 9, then ctrl_start, stream 16 samples -> exactly 8 beats starting with the first post-reset sample in lane 0; tlast on beat 8; frame_cnt = 1.
